// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Channel index width; a 1-bit index is kept even for degenerate counts.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin request search with a last-grant pointer; the pointer moves only on advance.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o
);

  logic [CH_W-1:0] ptr_q;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    int  c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(ptr_q) + i) % NUM_CH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= CH_W'(NUM_CH - 1);
    end else if (advance_i) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a registered output stage; select or round-robin.
// Handshake: a beat moves on channel k when i_valid[k] && o_ready[k]; the output beat
// leaves when o_valid && i_ready, and the register reloads only when empty or draining.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int        NUM_CH = 4,
  parameter  int        DATA_W = 8,
  parameter  mux_mode_e MODE   = MODE_SEL,
  localparam int        CH_W   = ch_width(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_valid,
  output logic [NUM_CH-1:0]        o_ready,
  input  logic [CH_W-1:0]          i_sel,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic [CH_W-1:0]          o_ch,
  input  logic                     i_ready
);

  logic              load;
  logic              xfer;
  logic              run_q;
  logic [NUM_CH-1:0] cand_oh;
  logic [CH_W-1:0]   cand_idx;
  logic [DATA_W-1:0] pick_data;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CH_W-1:0]   ch_d, ch_q;
  logic              valid_d, valid_q;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^i_sel;
      rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .req_i    (i_valid),
        .advance_i(xfer),
        .gnt_o    (cand_oh),
        .idx_o    (cand_idx)
      );
    end else begin : g_sel
      always_comb begin
        cand_oh  = '0;
        cand_idx = i_sel;
        if (int'(i_sel) < NUM_CH) cand_oh[i_sel] = 1'b1;
      end
    end
  endgenerate

  assign load = !valid_q || i_ready;

  // run_q holds o_ready low through the first edge after reset release.
  assign o_ready = (i_rst_n && run_q && load) ? cand_oh : '0;
  assign xfer    = |(i_valid & o_ready);

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (o_ready[k]) pick_data = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (load) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = pick_data;
        ch_d   = cand_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      run_q   <= 1'b1;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench: select-mode and round-robin instances at 4 channels, plus a 5-channel
// select instance so an out-of-range select value is representable.
module tb_stream_mux_nto1;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic [1:0]  i_sel;
  logic        i_ready;
  logic [39:0] i_data5;
  logic [4:0]  i_valid5;
  logic [2:0]  i_sel5;

  logic [3:0] sel_ready, rr_ready;
  logic [7:0] sel_data,  rr_data;
  logic       sel_valid, rr_valid;
  logic [1:0] sel_ch,    rr_ch;
  logic [4:0] s5_ready;
  logic [7:0] s5_data;
  logic       s5_valid;
  logic [2:0] s5_ch;

  int n_checks = 0;
  int n_errors = 0;

  stream_mux_nto1 #(.NUM_CH(4), .DATA_W(8), .MODE(stream_mux_pkg::MODE_SEL)) u_sel (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(sel_ready),
    .i_sel(i_sel), .o_data(sel_data), .o_valid(sel_valid), .o_ch(sel_ch), .i_ready(i_ready)
  );

  stream_mux_nto1 #(.NUM_CH(4), .DATA_W(8), .MODE(stream_mux_pkg::MODE_RR)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(rr_ready),
    .i_sel(i_sel), .o_data(rr_data), .o_valid(rr_valid), .o_ch(rr_ch), .i_ready(i_ready)
  );

  stream_mux_nto1 #(.NUM_CH(5), .DATA_W(8), .MODE(stream_mux_pkg::MODE_SEL)) u_sel5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data5), .i_valid(i_valid5), .o_ready(s5_ready),
    .i_sel(i_sel5), .o_data(s5_data), .o_valid(s5_valid), .o_ch(s5_ch), .i_ready(i_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    i_data   = 32'h0;
    i_valid  = 4'b1111;
    i_sel    = 2'd0;
    i_ready  = 1'b1;
    i_data5  = 40'h0;
    i_valid5 = 5'b0;
    i_sel5   = 3'd0;
    #1;
    check("rst sel o_valid", 32'(sel_valid), 32'd0);
    check("rst sel o_data",  32'(sel_data),  32'h00);
    check("rst sel o_ready", 32'(sel_ready), 32'h0);
    check("rst rr o_ready",  32'(rr_ready),  32'h0);
    step();
    step();
    i_valid = 4'b0000;
    rst_n   = 1'b1;
    step();
    step();

    // select mode: ch2 carries 0xA5
    i_sel   = 2'd2;
    i_data  = 32'h00A5_0000;
    i_valid = 4'b0100;
    i_ready = 1'b1;
    #1;
    check("sel ready ch2", 32'(sel_ready), 32'b0100);
    step();
    check("sel valid A5", 32'(sel_valid), 32'd1);
    check("sel data A5",  32'(sel_data),  32'hA5);
    check("sel ch A5",    32'(sel_ch),    32'd2);

    // backpressure with a second beat waiting upstream
    i_ready = 1'b0;
    i_data  = 32'h005A_0000;
    #1;
    check("bp ready", 32'(sel_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) i_sel = 2'd1;
      check("bp hold data",  32'(sel_data),  32'hA5);
      check("bp hold valid", 32'(sel_valid), 32'd1);
      check("bp hold ch",    32'(sel_ch),    32'd2);
      check("bp hold ready", 32'(sel_ready), 32'h0);
    end
    i_sel   = 2'd2;
    i_ready = 1'b1;
    #1;
    check("bp release ready", 32'(sel_ready), 32'b0100);
    step();
    check("bp next data", 32'(sel_data), 32'h5A);
    check("bp next ch",   32'(sel_ch),   32'd2);

    // 5-channel instance: select 4, then out-of-range 5 and 7
    i_data5  = 40'h44_33_22_11_00;
    i_valid5 = 5'b11111;
    i_sel5   = 3'd4;
    #1;
    check("s5 ready ch4", 32'(s5_ready), 32'b10000);
    step();
    check("s5 valid", 32'(s5_valid), 32'd1);
    check("s5 data",  32'(s5_data),  32'h44);
    check("s5 ch",    32'(s5_ch),    32'd4);
    i_sel5 = 3'd5;
    #1;
    check("s5 oor ready", 32'(s5_ready), 32'h0);
    step();
    check("s5 drained valid", 32'(s5_valid), 32'd0);
    check("s5 drained data",  32'(s5_data),  32'h44);
    check("s5 drained ch",    32'(s5_ch),    32'd4);
    i_sel5 = 3'd7;
    #1;
    check("s5 sel7 ready", 32'(s5_ready), 32'h0);

    // mid-stream reset while u_sel holds 0x5A
    i_ready = 1'b0;
    step();
    check("pre-rst valid", 32'(sel_valid), 32'd1);
    #3;
    i_ready = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("midrst valid", 32'(sel_valid), 32'd0);
    check("midrst data",  32'(sel_data),  32'h00);
    check("midrst ch",    32'(sel_ch),    32'd0);
    check("midrst ready", 32'(sel_ready), 32'h0);

    // round-robin: all channels valid
    i_data  = 32'h1312_1110;
    i_valid = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rr release no xfer", 32'(rr_valid), 32'd0);
    check("rr first ready",     32'(rr_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr seq valid", 32'(rr_valid), 32'd1);
      check("rr seq ch",    32'(rr_ch),    32'(k % 4));
      check("rr seq data",  32'(rr_data),  32'h10 + 32'(k % 4));
    end

    // only ch1 and ch3 valid after a ch3 grant: wrap to ch1
    i_valid = 4'b1010;
    #1;
    check("rr wrap ready", 32'(rr_ready), 32'b0010);
    step();
    check("rr wrap ch1",   32'(rr_ch),   32'd1);
    check("rr wrap d1",    32'(rr_data), 32'h11);
    step();
    check("rr wrap ch3",   32'(rr_ch),   32'd3);
    step();
    check("rr wrap ch1b",  32'(rr_ch),   32'd1);

    // backpressure freezes pointer; idle cycle drops valid but holds data
    i_ready = 1'b0;
    #1;
    check("rr bp ready", 32'(rr_ready), 32'h0);
    step();
    check("rr bp ch",    32'(rr_ch),    32'd1);
    check("rr bp valid", 32'(rr_valid), 32'd1);
    i_valid = 4'b0000;
    i_ready = 1'b1;
    step();
    check("rr idle valid", 32'(rr_valid), 32'd0);
    check("rr idle data",  32'(rr_data),  32'h11);
    check("rr idle ch",    32'(rr_ch),    32'd1);
    i_valid = 4'b1010;
    #1;
    check("rr resume ready", 32'(rr_ready), 32'b1000);
    step();
    check("rr resume ch", 32'(rr_ch), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
